// File: rtl/pc_if.sv
// Fetch-control bundle between the sequencer and the PC stage.
// The master drives control requests; the slave returns PC and stack state.
interface pc_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    logic             en;
    logic             jmp;
    logic             brz;
    logic             zero_flag;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic [SPW-1:0]   sp;
    logic             stack_ovf;
    logic             stack_unf;

    modport master (
        output en, jmp, brz, zero_flag, call, ret, target, clr_err,
        input  pc, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  en, jmp, brz, zero_flag, call, ret, target, clr_err,
        output pc, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with jump, branch-if-zero and call/return stack.
// Priority ret > call > jmp > brz > increment; stack misuse sets sticky flags.
module pc_unit #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input logic  clk,
    input logic  rst_n,
    pc_if.slave  bus
);
    localparam int IW  = $clog2(STACK_DEPTH);
    localparam int SPW = IW + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [WIDTH-1:0] stack_d [STACK_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic             full;
    logic             empty;

    // Derived stack pointers; the MSB of sp is set only when the stack is full.
    always_comb begin
        pc_inc   = pc_q + 1'b1;
        push_idx = sp_q[IW-1:0];
        top_idx  = IW'(sp_q - 1'b1);
        full     = sp_q[IW];
        empty    = (sp_q == '0);
    end

    // Next-state selection: errors raised this cycle override clr_err.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (bus.en) begin
            if (bus.ret) begin
                if (empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d = stack_q[top_idx];
                    sp_d = sp_q - 1'b1;
                end
            end else if (bus.call) begin
                if (full) begin
                    pc_d  = pc_inc;
                    ovf_d = 1'b1;
                end else begin
                    stack_d[push_idx] = pc_inc;
                    sp_d              = sp_q + 1'b1;
                    pc_d              = bus.target;
                end
            end else if (bus.jmp) begin
                pc_d = bus.target;
            end else if (bus.brz && bus.zero_flag) begin
                pc_d = bus.target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // State registers with asynchronous clear of PC, stack and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    // Every output is a flop.
    always_comb begin
        bus.pc        = pc_q;
        bus.sp        = sp_q;
        bus.stack_ovf = ovf_q;
        bus.stack_unf = unf_q;
    end
endmodule
